ov7670_capture: RTL
===================

Name: ov7670_capture

Overview:
- Camera-side capture stage. Runs on the OV7670 pixel clock, reassembles the camera's byte stream (two bytes per RGB565 pixel) into 16-bit pixels, and generates linear write addresses 0..76799 plus a write strobe into the 320x240 frame buffer.
- The 25 MHz display controller reads the same buffer by pixel_address/pixel_data.
- Also provides frame-level status: frame done, pixel count, overflow and odd-byte errors.

Parameters:
- H_PIXELS, 320, pixels per line.
- V_LINES, 240, lines per frame.
- ADDR_W, 17, write address width; must satisfy 2^ADDR_W >= H_PIXELS*V_LINES.

Ports:
- PCLK  in  1  camera pixel clock; the only clock.
- Nreset  in  1  synchronous, active-low reset.
- capture_en  in  1  capture enable; sampled only at frame start.
- vsync  in  1  camera VSYNC, active high during vertical blanking.
- href  in  1  camera HREF, high during valid line bytes.
- din  in  8  camera data bus.
- we  out  1  frame buffer write strobe.
- waddr  out  ADDR_W  frame buffer write address.
- wdata  out  16  RGB565 pixel, first byte = [15:8].
- frame_done  out  1  one-cycle pulse at the end of each captured frame.
- frame_pixels  out  ADDR_W  pixels written in the last completed frame.
- overflow  out  1  sticky per frame: pixels arrived beyond H_PIXELS*V_LINES.
- odd_byte  out  1  sticky per frame: href fell with an unpaired byte.

Behaviour:
- One clock (PCLK); reset is synchronous, active-low (Nreset).
- Reset (Nreset=0 at a PCLK edge):
  - we=0, waddr=0, wdata=0, frame_done=0, frame_pixels=0, overflow=0, odd_byte=0.
  - State=WAIT_VS; byte phase=0.
  - Reset mid-frame abandons the frame; no frame_done is produced for it.
- Input stage: vsync, href and din are registered once on PCLK (s_vsync, s_href, s_din). All logic below uses the registered copies. vsync edges are detected against the previous s_vsync.
- States:
  - WAIT_VS: wait for s_vsync=1, then go to VBLANK. Ignores href.
  - VBLANK:
    - On s_vsync falling: if capture_en=1, go to ACTIVE, clear the address counter, pixel count, overflow and odd_byte.
    - If capture_en=0, stay in VBLANK and skip this frame; the buffer is held frozen.
  - ACTIVE:
    - Capture bytes.
    - On s_vsync rising: pulse frame_done for 1 cycle, latch frame_pixels=count, go to VBLANK.
- Byte pairing (ACTIVE only):
  - While s_href=1, phase toggles every cycle.
  - Phase 0: latch s_din into hi.
  - Phase 1: form pixel {hi, s_din}.
  - When s_href=0, phase is forced to 0. If phase was 1 (unpaired byte), set odd_byte and discard the byte.
- Write timing:
  - The pixel formed at the phase-1 edge is presented as registered outputs on the next cycle: we=1 for exactly 1 cycle, with wdata and waddr valid during that cycle.
  - Latency: second byte on the pins at edge k, then we=1 in the cycle following edge k+2.
  - Maximum write rate: 1 per 2 PCLK.
- Addressing:
  - waddr starts at 0 for the first pixel of a frame and increments by 1 after each write. The address is linear: row*H_PIXELS+col, with no row reset. Frame realignment is done by vsync only.
  - Max address is H_PIXELS*V_LINES-1 (76799). Pixels beyond it: we stays 0, waddr holds at 76799, overflow=1 until the next frame start, and count saturates at H_PIXELS*V_LINES.
- Short frame: vsync rising before 76800 pixels still pulses frame_done. frame_pixels holds the actual count; no error flag is raised.
- Simultaneous vsync rise and phase-1 byte: the pixel is written, then the frame closes. frame_pixels includes that pixel.
- frame_done is never asserted outside ACTIVE. we is never asserted outside ACTIVE.

Decomposition:
- Shared package cam_pkg:
  - FB_WIDTH=320, FB_HEIGHT=240, FB_PIXELS=76800, FB_ADDR_W=17.
  - Enum capture_state_t {WAIT_VS, VBLANK, ACTIVE}.
  - These constants are reused by the display controller and the frame buffer.
- One natural sub-module: cam_byte_pair. It holds the phase toggle, hi latch, pixel valid and odd-byte detect. The top module keeps the FSM, addressing and status.

Test Plan:
- Reset release, vsync pulse, then 240 lines of href=1 for 640 bytes with din=0xA0,0x5B repeating -> 76800 writes, wdata=0xA05B, waddr 0..76799 in order, frame_done once, frame_pixels=76800, flags 0.
- Bytes 0x12,0x34 as the first pair of the frame -> we=1 exactly 3 cycles after 0x34 is on din, waddr=0, wdata=0x1234; second pair writes at waddr=1.
- One line with 641 bytes (href falls mid-pair) -> odd_byte=1, line writes 320 pixels, stray byte not written, next line starts cleanly on phase 0.
- 241 lines of 640 bytes -> writes stop at waddr=76799, overflow=1, frame_pixels=76800; next frame start clears overflow.
- capture_en=0 at a vsync falling edge -> no we for that whole frame, no frame_done; capture_en=1 at the following frame resumes at waddr=0.
- Nreset=0 asserted mid-line after 1000 pixels -> all outputs 0 next cycle; after release, no writes until a full vsync high-then-low sequence occurs.

Source files
------------

// File: rtl/cam_pkg.sv
// Frame buffer geometry and capture FSM states shared by the camera capture,
// display controller and frame buffer.
package cam_pkg;

    localparam int FB_WIDTH  = 320;
    localparam int FB_HEIGHT = 240;
    localparam int FB_PIXELS = 76800;
    localparam int FB_ADDR_W = 17;

    typedef enum logic [1:0] {
        WAIT_VS = 2'd0,
        VBLANK  = 2'd1,
        ACTIVE  = 2'd2
    } capture_state_t;

endpackage

// File: rtl/cam_byte_pair.sv
// Pairs camera bytes into RGB565 pixels: first byte of a pair is the high byte.
// form_o/odd_o are combinational for the current edge; the pixel is registered.
module cam_byte_pair (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        en_i,
    input  logic        href_i,
    input  logic [7:0]  din_i,
    output logic        form_o,
    output logic        odd_o,
    output logic        pix_valid_o,
    output logic [15:0] pix_data_o
);

    logic        phase_q, phase_d;
    logic [7:0]  hi_q, hi_d;
    logic        valid_q, valid_d;
    logic [15:0] pix_q, pix_d;

    // Phase toggle, high-byte latch and unpaired-byte detection
    always_comb begin
        phase_d = 1'b0;
        hi_d    = hi_q;
        valid_d = 1'b0;
        pix_d   = pix_q;
        form_o  = 1'b0;
        odd_o   = 1'b0;
        if (en_i) begin
            if (href_i) begin
                phase_d = ~phase_q;
                if (phase_q) begin
                    form_o  = 1'b1;
                    valid_d = 1'b1;
                    pix_d   = {hi_q, din_i};
                end else begin
                    hi_d = din_i;
                end
            end else begin
                odd_o = phase_q;
            end
        end else begin
            phase_d = 1'b0;
        end
    end

    // Pairing state register
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            phase_q <= 1'b0;
            hi_q    <= 8'h00;
            valid_q <= 1'b0;
            pix_q   <= 16'h0000;
        end else begin
            phase_q <= phase_d;
            hi_q    <= hi_d;
            valid_q <= valid_d;
            pix_q   <= pix_d;
        end
    end

    assign pix_valid_o = valid_q;
    assign pix_data_o  = pix_q;

endmodule

// File: rtl/ov7670_capture.sv
// OV7670 capture: vsync-framed FSM, linear write addressing into the frame
// buffer and per-frame status (done pulse, pixel count, overflow, odd byte).
module ov7670_capture
    import cam_pkg::*;
#(
    parameter int H_PIXELS = FB_WIDTH,
    parameter int V_LINES  = FB_HEIGHT,
    parameter int ADDR_W   = FB_ADDR_W
) (
    input  logic              PCLK,
    input  logic              Nreset,
    input  logic              capture_en,
    input  logic              vsync,
    input  logic              href,
    input  logic [7:0]        din,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [15:0]       wdata,
    output logic              frame_done,
    output logic [ADDR_W-1:0] frame_pixels,
    output logic              overflow,
    output logic              odd_byte
);

    localparam logic [ADDR_W-1:0] NPIX = ADDR_W'(H_PIXELS * V_LINES);

    logic              s_vsync_q, s_href_q, vs_prev_q;
    logic [7:0]        s_din_q;
    capture_state_t    state_q, state_d;
    logic [ADDR_W-1:0] count_q, count_d;
    logic [ADDR_W-1:0] slot_addr_q, slot_addr_d;
    logic              slot_ok_q, slot_ok_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [15:0]       wdata_q, wdata_d;
    logic              done_q, done_d;
    logic [ADDR_W-1:0] fpix_q, fpix_d;
    logic              ovf_q, ovf_d;
    logic              odd_q, odd_d;

    logic              vs_rise_s, vs_fall_s, active_s;
    logic              form_s, odd_s, pix_valid_s;
    logic [15:0]       pix_data_s;

    assign vs_rise_s = s_vsync_q & ~vs_prev_q;
    assign vs_fall_s = ~s_vsync_q & vs_prev_q;
    assign active_s  = (state_q == ACTIVE);

    cam_byte_pair u_pair (
        .clk_i       (PCLK),
        .rst_n_i     (Nreset),
        .en_i        (active_s),
        .href_i      (s_href_q),
        .din_i       (s_din_q),
        .form_o      (form_s),
        .odd_o       (odd_s),
        .pix_valid_o (pix_valid_s),
        .pix_data_o  (pix_data_s)
    );

    // FSM, address slot allocation at pixel formation, write issue one cycle later
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        slot_addr_d = slot_addr_q;
        slot_ok_d   = 1'b0;
        we_d        = pix_valid_s & slot_ok_q;
        waddr_d     = we_d ? slot_addr_q : waddr_q;
        wdata_d     = we_d ? pix_data_s : wdata_q;
        done_d      = 1'b0;
        fpix_d      = fpix_q;
        ovf_d       = ovf_q;
        odd_d       = odd_q | odd_s;

        if (form_s) begin
            if (count_q == NPIX) begin
                ovf_d = 1'b1;
            end else begin
                slot_ok_d   = 1'b1;
                slot_addr_d = count_q;
                count_d     = count_q + ADDR_W'(1);
            end
        end else begin
            slot_ok_d = 1'b0;
        end

        case (state_q)
            WAIT_VS: begin
                if (s_vsync_q) begin
                    state_d = VBLANK;
                end else begin
                    state_d = WAIT_VS;
                end
            end
            VBLANK: begin
                if (vs_fall_s && capture_en) begin
                    state_d = ACTIVE;
                    count_d = '0;
                    ovf_d   = 1'b0;
                    odd_d   = 1'b0;
                end else begin
                    state_d = VBLANK;
                end
            end
            ACTIVE: begin
                // count_d already includes a pixel formed on this same edge
                if (vs_rise_s) begin
                    state_d = VBLANK;
                    done_d  = 1'b1;
                    fpix_d  = count_d;
                end else begin
                    state_d = ACTIVE;
                end
            end
            default: begin
                state_d = WAIT_VS;
            end
        endcase
    end

    // Input synchronisation and all capture state
    always_ff @(posedge PCLK) begin
        if (!Nreset) begin
            s_vsync_q   <= 1'b0;
            s_href_q    <= 1'b0;
            s_din_q     <= 8'h00;
            vs_prev_q   <= 1'b0;
            state_q     <= WAIT_VS;
            count_q     <= '0;
            slot_addr_q <= '0;
            slot_ok_q   <= 1'b0;
            we_q        <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= 16'h0000;
            done_q      <= 1'b0;
            fpix_q      <= '0;
            ovf_q       <= 1'b0;
            odd_q       <= 1'b0;
        end else begin
            s_vsync_q   <= vsync;
            s_href_q    <= href;
            s_din_q     <= din;
            vs_prev_q   <= s_vsync_q;
            state_q     <= state_d;
            count_q     <= count_d;
            slot_addr_q <= slot_addr_d;
            slot_ok_q   <= slot_ok_d;
            we_q        <= we_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            done_q      <= done_d;
            fpix_q      <= fpix_d;
            ovf_q       <= ovf_d;
            odd_q       <= odd_d;
        end
    end

    assign we           = we_q;
    assign waddr        = waddr_q;
    assign wdata        = wdata_q;
    assign frame_done   = done_q;
    assign frame_pixels = fpix_q;
    assign overflow     = ovf_q;
    assign odd_byte     = odd_q;

endmodule
